// File: rtl/hazard_scoreboard.sv
// Central decode/execute hazard controller: per-register result countdowns,
// stall/bubble/accept decision for the decoded instruction, and IF/ID flush sequencing.
module hazard_scoreboard #(
    parameter int NREG         = 32,
    parameter int LAT_W        = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rd,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic             issue_use_rs1,
    input  logic             issue_use_rs2,
    input  logic             issue_wb,
    input  logic [LAT_W-1:0] issue_latency,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             stall_o,
    output logic             bubble_o,
    output logic             flush_o,
    output logic             issue_ack,
    output logic [NREG-1:0]  busy_mask,
    output logic [15:0]      stall_count
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    logic [LAT_W-1:0] r_cnt [NREG];
    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_fcnt;
    logic [2:0]       w_fcnt_nxt;
    logic [15:0]      r_stall_cnt;
    logic [NREG-1:0]  w_busy;
    logic             w_hazard;
    logic             w_flushing;
    logic             w_stall;
    logic             w_ack;

    // Busy vector; x0 can never hold a pending producer.
    always_comb begin
        w_busy = '0;
        for (int i = 1; i < NREG; i++) begin
            w_busy[i] = (r_cnt[i] != '0);
        end
    end

    // Issue decision: RAW on either source or WAW on the destination blocks acceptance.
    always_comb begin
        w_flushing = (r_state == S_FLUSH);
        w_hazard   = issue_valid & ((issue_use_rs1 & w_busy[issue_rs1]) |
                                    (issue_use_rs2 & w_busy[issue_rs2]) |
                                    (issue_wb      & w_busy[issue_rd]));
        w_stall    = !w_flushing & (mem_busy | w_hazard);
        w_ack      = issue_valid & !w_flushing & !mem_busy & !w_hazard;
    end

    assign stall_o     = w_stall;
    assign bubble_o    = !w_flushing & !mem_busy & w_hazard;
    assign flush_o     = w_flushing;
    assign issue_ack   = w_ack;
    assign busy_mask   = w_busy;
    assign stall_count = r_stall_cnt;

    // Countdown per register: new producer beats a same-cycle write-back clear.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_cnt[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (w_ack && issue_wb && (issue_rd == 5'(i))) begin
                    r_cnt[i] <= issue_latency;
                end else if (wb_en && (wb_rd == 5'(i))) begin
                    r_cnt[i] <= '0;
                end else if (!mem_busy && (r_cnt[i] != '0)) begin
                    r_cnt[i] <= r_cnt[i] - LAT_W'(1);
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
            end
        end
    end

    // Flush sequencer next state; a new taken branch restarts the window.
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            S_IDLE: begin
                if (branch_taken) begin
                    w_state_nxt = S_FLUSH;
                    w_fcnt_nxt  = FLUSH_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (branch_taken) begin
                    w_fcnt_nxt = FLUSH_LOAD;
                end else if (r_fcnt == 3'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_fcnt_nxt = r_fcnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_fcnt_nxt  = 3'd0;
            end
        endcase
    end

    // Flush sequencer state register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_fcnt  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Saturating stalled-cycle counter.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-cycle expectations queued at drive time
// and compared against the DUT, plus directed stall-length and flush-length checks.
module tb_hazard_scoreboard;

    logic        CLK = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_use_rs1, issue_use_rs2, issue_wb;
    logic [2:0]  issue_latency;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic        branch_taken, mem_busy;
    logic        stall_o, bubble_o, flush_o, issue_ack;
    logic [31:0] busy_mask;
    logic [15:0] stall_count;

    hazard_scoreboard #(.NREG(32), .LAT_W(3), .FLUSH_CYCLES(2)) dut (
        .CLK(CLK), .reset(reset), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_use_rs1(issue_use_rs1),
        .issue_use_rs2(issue_use_rs2), .issue_wb(issue_wb), .issue_latency(issue_latency),
        .wb_en(wb_en), .wb_rd(wb_rd), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .stall_o(stall_o), .bubble_o(bubble_o), .flush_o(flush_o), .issue_ack(issue_ack),
        .busy_mask(busy_mask), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        stall, bubble, flush, ack;
        logic [31:0] mask;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   m_cnt [32];
    bit   m_fl;
    int   m_fcnt;
    int   m_sc;
    logic last_ack, last_flush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: inputs already driven (just after negedge).
    task automatic cyc();
        exp_t        e;
        exp_t        p;
        logic [31:0] bm;
        logic        haz;
        bm = '0;
        for (int i = 1; i < 32; i++) bm[i] = (m_cnt[i] != 0);
        haz = issue_valid & ((issue_use_rs1 & bm[issue_rs1]) | (issue_use_rs2 & bm[issue_rs2]) |
                             (issue_wb & bm[issue_rd]));
        e.flush  = m_fl;
        e.stall  = !m_fl & (mem_busy | haz);
        e.bubble = !m_fl & !mem_busy & haz;
        e.ack    = issue_valid & !m_fl & !mem_busy & !haz;
        e.mask   = bm;
        e.sc     = 16'(m_sc);
        q.push_back(e);
        #1;
        p = q.pop_front();
        check("stall_o", {31'd0, stall_o}, {31'd0, p.stall});
        check("bubble_o", {31'd0, bubble_o}, {31'd0, p.bubble});
        check("flush_o", {31'd0, flush_o}, {31'd0, p.flush});
        check("issue_ack", {31'd0, issue_ack}, {31'd0, p.ack});
        check("busy_mask", busy_mask, p.mask);
        check("stall_count", {16'd0, stall_count}, {16'd0, p.sc});
        last_ack   = issue_ack;
        last_flush = flush_o;
        @(posedge CLK);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_fl = 1'b0; m_fcnt = 0; m_sc = 0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (p.ack && issue_wb && issue_rd == 5'(i)) m_cnt[i] = int'(issue_latency);
                else if (wb_en && wb_rd == 5'(i)) m_cnt[i] = 0;
                else if (!mem_busy && m_cnt[i] != 0) m_cnt[i] = m_cnt[i] - 1;
            end
            if (branch_taken) begin
                m_fl = 1'b1; m_fcnt = 1;
            end else if (m_fl) begin
                if (m_fcnt == 0) m_fl = 1'b0;
                else m_fcnt = m_fcnt - 1;
            end
            if (p.stall && m_sc < 65535) m_sc++;
        end
        @(negedge CLK);
    endtask

    task automatic set_issue(input int rd, input int rs1, input int rs2, input bit u1,
                             input bit u2, input bit wb, input int lat);
        issue_valid = 1'b1;
        issue_rd = 5'(rd); issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2);
        issue_use_rs1 = u1; issue_use_rs2 = u2; issue_wb = wb;
        issue_latency = 3'(lat);
    endtask

    // Present an instruction until accepted; returns the number of held cycles.
    task automatic issue_wait(input int rd, input int rs1, input int rs2, input bit u1,
                              input bit u2, input bit wb, output int stalls);
        stalls = 0;
        set_issue(rd, rs1, rs2, u1, u2, wb, 0);
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (last_ack) break;
            stalls++;
        end
        if (!last_ack) check("issue_timeout", 32'd0, 32'd1);
        issue_valid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int nf;
        reset = 1'b1; issue_valid = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
        issue_use_rs1 = 1'b0; issue_use_rs2 = 1'b0; issue_wb = 1'b0; issue_latency = 3'd0;
        wb_en = 1'b0; wb_rd = 5'd0; branch_taken = 1'b0; mem_busy = 1'b0;
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_fl = 1'b0; m_fcnt = 0; m_sc = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        cyc();
        reset = 1'b0;

        // load-use: lw x5 then add x6,x5,x5
        set_issue(5, 0, 0, 1'b0, 1'b0, 1'b1, 1);
        cyc();
        check("lu_mask", busy_mask, 32'h20);
        issue_wait(6, 5, 5, 1'b1, 1'b1, 1'b1, st);
        check("lu_stalls", 32'(st), 32'd1);
        check("lu_sc", {16'd0, stall_count}, 32'd1);
        cyc();

        // divide latency 5, consumer after one gap cycle
        set_issue(7, 1, 2, 1'b1, 1'b1, 1'b1, 5);
        cyc();
        issue_valid = 1'b0;
        cyc();
        issue_wait(8, 7, 7, 1'b1, 1'b1, 1'b1, st);
        check("div_stalls", 32'(st), 32'd4);

        // early completion by write-back two cycles after issue
        set_issue(7, 1, 2, 1'b1, 1'b1, 1'b1, 5);
        cyc();
        set_issue(8, 7, 0, 1'b1, 1'b0, 1'b1, 0);
        cyc();
        wb_en = 1'b1; wb_rd = 5'd7;
        cyc();
        wb_en = 1'b0;
        cyc();
        check("early_ack", {31'd0, last_ack}, 32'd1);
        issue_valid = 1'b0;
        cyc();

        // x0 is never busy
        set_issue(0, 1, 1, 1'b1, 1'b0, 1'b1, 3);
        cyc();
        issue_valid = 1'b0;
        check("x0_mask", busy_mask, 32'h0);
        issue_wait(10, 0, 0, 1'b1, 1'b1, 1'b1, st);
        check("x0_stalls", 32'(st), 32'd0);

        // WAW on x9
        set_issue(9, 1, 0, 1'b1, 1'b0, 1'b1, 1);
        cyc();
        issue_wait(9, 0, 0, 1'b0, 1'b0, 1'b1, st);
        check("waw_stalls", 32'(st), 32'd1);
        cyc();

        // mem_busy freezes the countdown for three cycles
        set_issue(3, 1, 1, 1'b1, 1'b0, 1'b1, 4);
        cyc();
        set_issue(11, 3, 3, 1'b1, 1'b1, 1'b1, 0);
        st = 0;
        for (int k = 0; k < 20; k++) begin
            mem_busy = (k >= 1 && k <= 3);
            cyc();
            if (last_ack) break;
            st++;
        end
        mem_busy = 1'b0; issue_valid = 1'b0;
        check("mb_stalls", 32'(st), 32'd7);

        // branch flush with an instruction waiting in ID
        branch_taken = 1'b1;
        cyc();
        branch_taken = 1'b0;
        set_issue(12, 1, 1, 1'b1, 1'b1, 1'b1, 0);
        nf = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (!last_flush) break;
            nf++;
        end
        issue_valid = 1'b0;
        check("flush_len", 32'(nf), 32'd2);

        // second branch in the first flush cycle extends the window
        branch_taken = 1'b1;
        cyc();
        cyc();
        branch_taken = 1'b0;
        nf = 1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (!last_flush) break;
            nf++;
        end
        check("flush_restart_len", 32'(nf), 32'd3);

        // random traffic against the model
        for (int k = 0; k < 300; k++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd = 5'($urandom_range(0, 7)); issue_rs1 = 5'($urandom_range(0, 7));
            issue_rs2 = 5'($urandom_range(0, 7));
            issue_use_rs1 = 1'($urandom_range(0, 1)); issue_use_rs2 = 1'($urandom_range(0, 1));
            issue_wb = 1'($urandom_range(0, 1)); issue_latency = 3'($urandom_range(0, 7));
            wb_en = ($urandom_range(0, 7) == 0); wb_rd = 5'($urandom_range(0, 7));
            branch_taken = ($urandom_range(0, 15) == 0); mem_busy = ($urandom_range(0, 7) == 0);
            cyc();
        end
        issue_valid = 1'b0; wb_en = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
        cyc();

        // reset while flushing with x5 counting down
        set_issue(5, 0, 0, 1'b0, 1'b0, 1'b1, 3);
        branch_taken = 1'b1;
        cyc();
        issue_valid = 1'b0; branch_taken = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst_flush", {31'd0, flush_o}, 32'd0);
        check("rst_mask", busy_mask, 32'd0);
        check("rst_sc", {16'd0, stall_count}, 32'd0);

        // saturation of the stall counter
        mem_busy = 1'b1;
        repeat (70000) @(posedge CLK);
        @(negedge CLK);
        m_sc = 65535;
        check("sat_sc", {16'd0, stall_count}, 32'h0000FFFF);
        cyc();
        mem_busy = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
